h2f_buff_reader: RTL and testbench
==================================

Name: h2f_buff_reader

Overview:
FPGA-side read master for the 128-bit port of the HPS-to-FPGA on-chip buffer: after the HPS fills the buffer through the 32-bit port, this block fetches a command-specified run of 128-bit words and presents them as a valid/ready stream.
- It sits between the buffer's FPGA-facing slave port and the downstream compute datapath.
- It absorbs the buffer's fixed 1-cycle read latency and downstream backpressure with a small FIFO.

Parameters:
- DATA_W, 128, buffer/stream word width.
- ADDR_W, 8, buffer word address width (256 words).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address, sampled with start.
- word_count  in  ADDR_W+1  words to read, 0..256; values >256 treated as 256.
- abort  in  1  cancel current transfer.
- busy  out  1  high from cycle after accepted start until return to IDLE.
- done  out  1  one-cycle pulse: transfer completed or aborted.
- aborted  out  1  valid with done; 1 if terminated by abort.
- buf_address  out  ADDR_W  buffer port address.
- buf_chipselect  out  1  read issue qualifier.
- buf_clken  out  1  tied 1 when not in reset.
- buf_write  out  1  constant 0.
- buf_readdata  in  DATA_W  buffer read data, valid the cycle after address issue.
- out_data  out  DATA_W  stream data (FIFO head).
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  marks final word of transfer.

Behaviour:
- Reset (async assert, sync deassert by upstream): all outputs 0, FIFO empty, FSM IDLE, no read in flight.
- FSM states:
  - IDLE: start=1 latches base/count; goes to RUN, or to DONE if count=0. start outside IDLE is ignored.
  - RUN: issues reads until all words are issued, then goes to DRAIN.
  - DRAIN: waits for last word handshake, then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Read issue in RUN: buf_chipselect=1 with buf_address=next address only when (FIFO occupancy + reads in flight) < FIFO_DEPTH. Occupancy is the pre-pop value for that cycle. At most one read issues per cycle.
- Address increments modulo 2^ADDR_W: 0xFF wraps to 0x00.
- Data issued in cycle k is pushed into the FIFO at the end of k+1 from buf_readdata.
- Latency: start in cycle N; first issue in N+1; out_valid=1 with word0 in N+3. With out_ready held high, one word per cycle, no bubbles.
- Handshake: a transfer occurs when out_valid & out_ready. out_data/out_valid/out_last stay stable while out_valid & !out_ready.
- out_last=1 only on the final word of the transfer.
- done pulses in the cycle after the last handshake; busy drops in the same cycle done is high.
- Simultaneous FIFO push and pop in one cycle is allowed; occupancy is unchanged.
- abort (RUN or DRAIN):
  - FIFO flushes and the in-flight read is discarded; no further issue.
  - Next cycle is DONE with aborted=1.
  - out_valid=0 from the cycle after abort.
  - abort in IDLE/DONE is ignored.
  - abort and start together in IDLE: start wins.
- Reset mid-transfer: immediate return to reset state; no done pulse.

Test Plan:
- base=0x10, count=4, ready=1, buffer preloaded addr i -> data {4{i}}: issue 0x10..0x13 in N+1..N+4; valid N+3..N+6; last on 0x13 word; done at N+7.
- base=0xFE, count=4: addresses FE,FF,00,01 in order; out_last on word from 0x01.
- count=16, ready low cycles N+4..N+15:
  - outstanding+occupancy never exceeds 4; chipselect stalls.
  - All 16 words delivered in order, none lost or duplicated; data stable while stalled.
- count=0: busy never asserted; done=1, aborted=0 at N+1; no chipselect.
- count=256 base=0x80 ready=1: 256 words, addr wraps at 0xFF; done once; second start during busy ignored (no extra reads).
- abort in RUN after 3 handshakes of 10: out_valid=0 next cycle; done=1, aborted=1 next; then reset_n pulsed mid second transfer -> all outputs 0 immediately.

Source files
------------

// File: rtl/h2f_buff_reader.sv
// FPGA-side read master for the 128-bit port of the HPS-to-FPGA on-chip buffer.
// Fetches a run of words and presents them as a valid/ready stream through a small FIFO.
module h2f_buff_reader #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] buf_address,
    output logic              buf_chipselect,
    output logic              buf_clken,
    output logic              buf_write,
    input  logic [DATA_W-1:0] buf_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WC_W  = ADDR_W + 1;
    localparam logic [WC_W-1:0] MAX_WORDS = WC_W'(2 ** ADDR_W);
    localparam logic [CNT_W:0]  DEPTH_V   = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic [WC_W-1:0]     r_left;
    logic                r_inflight;
    logic                r_inflight_last;
    logic                r_aborted;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_mem_last;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic [WC_W-1:0]     w_count_clamped;
    logic                w_accept;
    logic                w_active;
    logic                w_flush;
    logic                w_credit;
    logic                w_issue;
    logic                w_issue_last;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_valid;
    logic                w_head_last;

    assign w_count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
    assign w_accept        = (r_state == S_IDLE) && start;
    assign w_active        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_flush         = w_active && abort;

    // Credit counts reads already in flight so the FIFO can always absorb returning data.
    assign w_credit     = ((CNT_W + 1)'(r_count) + (CNT_W + 1)'(r_inflight)) < DEPTH_V;
    assign w_issue      = (r_state == S_RUN) && (r_left != '0) && w_credit;
    assign w_issue_last = w_issue && (r_left == WC_W'(1));

    assign w_fifo_valid = (r_count != '0);
    assign w_head_last  = r_mem_last[r_rd_ptr];
    assign w_push       = r_inflight;
    assign w_pop        = w_fifo_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_count_clamped == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if (w_issue_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if (w_pop && w_head_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        aborted        = 1'b0;
        buf_chipselect = 1'b0;
        buf_address    = '0;
        case (r_state)
            S_RUN: begin
                busy           = 1'b1;
                buf_chipselect = w_issue;
                buf_address    = w_issue ? r_addr : '0;
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                aborted = r_aborted;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Stream outputs are forced to zero whenever the FIFO is empty.
    always_comb begin
        out_valid = w_fifo_valid;
        out_data  = w_fifo_valid ? r_mem[r_rd_ptr] : '0;
        out_last  = w_fifo_valid && w_head_last;
    end

    assign buf_clken = reset_n;
    assign buf_write = 1'b0;

    // Command capture and read issue bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr          <= '0;
            r_left          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= base_addr;
                r_left <= w_count_clamped;
            end else if (w_issue) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_left <= r_left - WC_W'(1);
            end
            if (w_flush) begin
                r_inflight      <= 1'b0;
                r_inflight_last <= 1'b0;
            end else begin
                r_inflight      <= w_issue;
                r_inflight_last <= w_issue_last;
            end
        end
    end

    // Abort flag reported alongside the done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_aborted <= 1'b0;
        end else if (w_flush) begin
            r_aborted <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_aborted <= 1'b0;
        end
    end

    // FIFO pointers, occupancy and last-flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_mem_last <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // FIFO data storage; contents are masked at the output while empty
    always_ff @(posedge clk) begin
        if (w_push && !w_flush) begin
            r_mem[r_wr_ptr] <= buf_readdata;
        end
    end

endmodule

// File: tb/tb_h2f_buff_reader.sv
// Bench for h2f_buff_reader: models the on-chip buffer and checks the stream
// against the expected word sequence derived from base/count.
module tb_h2f_buff_reader;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [ADDR_W-1:0] buf_address;
    logic              buf_chipselect;
    logic              buf_clken;
    logic              buf_write;
    logic [DATA_W-1:0] buf_readdata = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    logic [DATA_W-1:0] bmem [256];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    h2f_buff_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .buf_address    (buf_address),
        .buf_chipselect (buf_chipselect),
        .buf_clken      (buf_clken),
        .buf_write      (buf_write),
        .buf_readdata   (buf_readdata),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last)
    );

    // Buffer slave: one-cycle read latency
    always @(posedge clk) begin
        if (buf_chipselect) buf_readdata <= bmem[buf_address];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_data(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_busy"},   int'(busy), 0);
        chk({pfx, "_done"},   int'(done), 0);
        chk({pfx, "_abrt"},   int'(aborted), 0);
        chk({pfx, "_cs"},     int'(buf_chipselect), 0);
        chk({pfx, "_addr"},   int'(buf_address), 0);
        chk({pfx, "_clken"},  int'(buf_clken), 0);
        chk({pfx, "_wr"},     int'(buf_write), 0);
        chk({pfx, "_valid"},  int'(out_valid), 0);
        chk_data({pfx, "_data"}, out_data, '0);
        chk({pfx, "_last"},   int'(out_last), 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) bmem[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // mode: 0 ready high, 1 ready low in cycles 4..15, 2 random ready.
    // Cycle k is counted from the start cycle N (k=1 is N+1).
    task automatic run_xfer(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt,
                            input int mode, input int abort_after, input int stop_at,
                            input bit second_start,
                            output int done_cyc, output int first_iss, output int first_val);
        int exp_n;
        int issued;
        int delivered;
        int abort_cyc;
        int limit;
        logic rdy;
        logic pv;
        logic pr;
        logic pl;
        logic [DATA_W-1:0] pd;
        logic [ADDR_W-1:0] idx;
        exp_n     = (int'(cnt) > 256) ? 256 : int'(cnt);
        issued    = 0;
        delivered = 0;
        abort_cyc = -1;
        limit     = 4 * exp_n + 40;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        done_cyc = -1; first_iss = -1; first_val = -1;

        @(negedge clk);
        start = 1'b1; base_addr = base; word_count = cnt; abort = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            start = second_start && (k == 5);
            if (start) begin
                base_addr  = 8'h00;
                word_count = 9'd3;
            end
            abort = 1'b0;
            if (abort_after >= 0 && abort_cyc < 0 && delivered == abort_after) begin
                abort     = 1'b1;
                abort_cyc = k;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = !(k >= 4 && k <= 15);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            if (abort) rdy = 1'b0;
            out_ready = rdy;
            if (stop_at > 0 && k == stop_at) return;

            chk("busy", int'(busy), int'(!done));
            if (abort_cyc > 0 && k == abort_cyc + 1) begin
                chk("abort_valid", int'(out_valid), 0);
                chk("abort_done", int'(done), 1);
            end
            if (buf_chipselect) begin
                if (first_iss < 0) first_iss = k;
                idx = base + ADDR_W'(issued);
                chk("issue_addr", int'(buf_address), int'(idx));
                issued++;
                chk("issue_bound", int'(issued - delivered <= 4), 1);
                chk("issue_count", int'(issued <= exp_n), 1);
            end
            if (pv && !pr && !(abort_cyc > 0 && k == abort_cyc + 1)) begin
                chk("hold_valid", int'(out_valid), 1);
                chk_data("hold_data", out_data, pd);
                chk("hold_last", int'(out_last), int'(pl));
            end
            if (out_valid && first_val < 0) first_val = k;
            if (out_valid && rdy) begin
                idx = base + ADDR_W'(delivered);
                chk_data("data", out_data, bmem[idx]);
                chk("last", int'(out_last), int'(delivered == exp_n - 1));
                delivered++;
            end
            pv = out_valid; pr = rdy; pd = out_data; pl = out_last;
            if (done) begin
                done_cyc = k;
                chk("aborted_flag", int'(aborted), int'(abort_cyc > 0));
                if (abort_cyc < 0) begin
                    chk("delivered", delivered, exp_n);
                    chk("issued", issued, exp_n);
                end
                break;
            end
        end
        if (done_cyc < 0) chk("timeout", 0, 1);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_valid", int'(out_valid), 0);
        chk("idle_cs", int'(buf_chipselect), 0);
    endtask

    int dc, fi, fv;
    logic [ADDR_W-1:0] rb;
    logic [ADDR_W:0]   rc;

    initial begin
        reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        abort = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 256; i++) bmem[i] = {4{32'(i)}};
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        reset_n = 1'b1;
        @(negedge clk);
        chk("clken", int'(buf_clken), 1);
        chk("write", int'(buf_write), 0);

        // Basic run with the counting pattern
        run_xfer(8'h10, 9'd4, 0, -1, 0, 1'b0, dc, fi, fv);
        chk("t1_first_issue", fi, 1);
        chk("t1_first_valid", fv, 3);
        chk("t1_done_cycle", dc, 7);

        // Address wrap
        fill_random();
        run_xfer(8'hFE, 9'd4, 0, -1, 0, 1'b0, dc, fi, fv);
        chk("t2_done_cycle", dc, 7);

        // Backpressure window
        run_xfer(8'h30, 9'd16, 1, -1, 0, 1'b0, dc, fi, fv);
        chk("t3_done_cycle", dc, 31);

        // Zero-length command
        run_xfer(8'h55, 9'd0, 0, -1, 0, 1'b0, dc, fi, fv);
        chk("t4_done_cycle", dc, 1);
        chk("t4_no_issue", fi, -1);

        // Full buffer with an ignored second start
        fill_random();
        run_xfer(8'h80, 9'd256, 0, -1, 0, 1'b1, dc, fi, fv);
        chk("t5_done_cycle", dc, 259);

        // Oversized count clamps to 256
        run_xfer(8'($urandom), 9'd300, 2, -1, 0, 1'b0, dc, fi, fv);

        // Random commands with random backpressure
        for (int t = 0; t < 4; t++) begin
            fill_random();
            rb = 8'($urandom);
            rc = 9'($urandom_range(1, 24));
            run_xfer(rb, rc, 2, -1, 0, 1'b0, dc, fi, fv);
        end

        // Abort after three handshakes
        run_xfer(8'h40, 9'd10, 0, 3, 0, 1'b0, dc, fi, fv);
        chk("t7_done_cycle", dc, 7);

        // Reset in the middle of a transfer
        run_xfer(8'h20, 9'd20, 0, -1, 5, 1'b0, dc, fi, fv);
        #1 reset_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        reset_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_cs", int'(buf_chipselect), 0);
            chk("post_rst_valid", int'(out_valid), 0);
        end

        // Recovery after reset
        run_xfer(8'hF0, 9'd20, 0, -1, 0, 1'b0, dc, fi, fv);
        chk("t8_done_cycle", dc, 23);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
